// File: rtl/axil_cfg_master_if.sv
// AXI4-Lite bus bundle between axil_cfg_master and the accelerator's s_axi_config port.
interface axil_cfg_master_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic                  AWVALID, AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic                  WVALID, WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  BVALID, BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID, ARREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic                  RVALID, RREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWADDR, input AWREADY,
    output WVALID, WDATA, WSTRB, input WREADY,
    input  BVALID, BRESP, output BREADY,
    output ARVALID, ARADDR, input ARREADY,
    input  RVALID, RDATA, RRESP, output RREADY
  );

  modport slave (
    input  AWVALID, AWADDR, output AWREADY,
    input  WVALID, WDATA, WSTRB, output WREADY,
    output BVALID, BRESP, input BREADY,
    input  ARVALID, ARADDR, output ARREADY,
    output RVALID, RDATA, RRESP, input RREADY
  );
endinterface

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite initiator turning cmd/resp requests into config-port accesses.
// Optional watchdog output `timeout` (and TIMEOUT_CYCLES) exists only with AXIL_CFG_TIMEOUT_EN.
module axil_cfg_master #(
  parameter int C_M_AXI_CONFIG_ADDR_WIDTH = 5,
  parameter int C_M_AXI_CONFIG_DATA_WIDTH = 32
`ifdef AXIL_CFG_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic                                   cmd_write,
  input  logic [C_M_AXI_CONFIG_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_CONFIG_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_CONFIG_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                                   resp_valid,
  input  logic                                   resp_ready,
  output logic [C_M_AXI_CONFIG_DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]                             resp_resp,
  axil_cfg_master_if.master                      m_axi_config
`ifdef AXIL_CFG_TIMEOUT_EN
  , output logic                                 timeout
`endif
);
  localparam int AW = C_M_AXI_CONFIG_ADDR_WIDTH;
  localparam int DW = C_M_AXI_CONFIG_DATA_WIDTH;
  localparam int SW = DW / 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_WB   = 3'd2;
  localparam logic [2:0] S_RA   = 3'd3;
  localparam logic [2:0] S_RD   = 3'd4;
  localparam logic [2:0] S_RESP = 3'd5;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } rsp_t;

  logic [2:0] state;
  req_t       req;
  rsp_t       rsp;
  logic       aw_vld, w_vld, ar_vld, b_rdy, r_rdy, rsp_vld;
  logic       aw_done, w_done;
  logic       accept, aw_hs, w_hs;

  // Reset gates cmd_ready so nothing looks accepted while the block is held.
  assign cmd_ready = (state == S_IDLE) & ap_rst_n;
  assign accept    = cmd_valid & cmd_ready;
  assign aw_hs     = aw_vld & m_axi_config.AWREADY;
  assign w_hs      = w_vld & m_axi_config.WREADY;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state   <= S_IDLE;
      req     <= '0;
      rsp     <= '0;
      aw_vld  <= 1'b0;
      w_vld   <= 1'b0;
      ar_vld  <= 1'b0;
      b_rdy   <= 1'b0;
      r_rdy   <= 1'b0;
      rsp_vld <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          req <= '{addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
          if (cmd_write) begin
            aw_vld  <= 1'b1;
            w_vld   <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= S_WR;
          end else begin
            ar_vld <= 1'b1;
            state  <= S_RA;
          end
        end
        // AW and W complete independently; B is only opened once both have gone.
        S_WR: begin
          if (aw_hs) begin
            aw_vld  <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            w_vld  <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done | aw_hs) & (w_done | w_hs)) begin
            b_rdy <= 1'b1;
            state <= S_WB;
          end
        end
        S_WB: if (m_axi_config.BVALID) begin
          b_rdy   <= 1'b0;
          rsp     <= '{rdata: '0, resp: m_axi_config.BRESP};
          rsp_vld <= 1'b1;
          state   <= S_RESP;
        end
        S_RA: if (m_axi_config.ARREADY) begin
          ar_vld <= 1'b0;
          r_rdy  <= 1'b1;
          state  <= S_RD;
        end
        S_RD: if (m_axi_config.RVALID) begin
          r_rdy   <= 1'b0;
          rsp     <= '{rdata: m_axi_config.RDATA, resp: m_axi_config.RRESP};
          rsp_vld <= 1'b1;
          state   <= S_RESP;
        end
        S_RESP: if (resp_ready) begin
          rsp_vld <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_axi_config.AWVALID = aw_vld;
  assign m_axi_config.AWADDR  = req.addr;
  assign m_axi_config.WVALID  = w_vld;
  assign m_axi_config.WDATA   = req.wdata;
  assign m_axi_config.WSTRB   = req.wstrb;
  assign m_axi_config.BREADY  = b_rdy;
  assign m_axi_config.ARVALID = ar_vld;
  assign m_axi_config.ARADDR  = req.addr;
  assign m_axi_config.RREADY  = r_rdy;

  assign resp_valid = rsp_vld;
  assign resp_rdata = rsp.rdata;
  assign resp_resp  = rsp.resp;

`ifdef AXIL_CFG_TIMEOUT_EN
  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt;
  logic          busy;

  assign busy = (state == S_WR) | (state == S_WB) | (state == S_RA) | (state == S_RD);

  // Flag only; the bus transaction keeps waiting so AXI ordering is never broken.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (accept) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (busy) begin
      if (to_cnt != TO_LIM) to_cnt <= to_cnt + 1'b1;
      if (to_cnt >= TO_LIM - 1'b1) timeout <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_axil_cfg_master.sv
// Randomised scoreboard bench for axil_cfg_master against a behavioural register-file slave.
module tb_axil_cfg_master;
  localparam int AW = 5;
  localparam int DW = 32;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          cmd_ready, resp_valid;
  logic          resp_ready = 1'b1;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_resp;
`ifdef AXIL_CFG_TIMEOUT_EN
  logic          timeout;
`endif

  axil_cfg_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axil_cfg_master #(.C_M_AXI_CONFIG_ADDR_WIDTH(AW), .C_M_AXI_CONFIG_DATA_WIDTH(DW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_resp(resp_resp),
    .m_axi_config(bus)
`ifdef AXIL_CFG_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { bit w; logic [31:0] rdata; logic [1:0] resp; } exp_t;
  exp_t        q[$];
  logic [31:0] ref_mem [8];
  int          n_wr_rsp = 0;

  // Register 7 answers SLVERR, register 6 DECERR; others are plain storage.
  function automatic logic [1:0] rule_resp(input int idx);
    return (idx == 7) ? 2'b10 : (idx == 6) ? 2'b11 : 2'b00;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 8; i++) ref_mem[i] = (i == 0) ? 32'h4 : 32'h0;
  endtask

  task automatic model_push(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int   idx;
    exp_t e;
    idx    = int'(a[4:2]);
    e.w    = w;
    e.resp = rule_resp(idx);
    if (w) begin
      e.rdata = 32'h0;
      if (e.resp == 2'b00)
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.rdata = (e.resp == 2'b00) ? ref_mem[idx] : 32'h0;
    end
    q.push_back(e);
  endtask

  // ---------------- slave with programmable ready/response delays ----------------
  logic [31:0]   s_mem [8];
  int            aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  int            aw_wait, w_wait, ar_wait, b_wait, r_wait;
  logic          aw_got, w_got, ar_got, bvalid, rvalid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [31:0]   s_wdata, rdata;
  logic [3:0]    s_wstrb;
  logic [1:0]    bresp, rresp;
  int            wr_count = 0;
  bit            ap_start_seen;

  assign bus.AWREADY = ap_rst_n && !aw_got && (aw_wait >= aw_dly);
  assign bus.WREADY  = ap_rst_n && !w_got  && (w_wait  >= w_dly);
  assign bus.ARREADY = ap_rst_n && !ar_got && (ar_wait >= ar_dly);
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.RVALID  = rvalid;
  assign bus.RDATA   = rdata;
  assign bus.RRESP   = rresp;

  always @(posedge ap_clk) begin : slave
    logic          aw_n, w_n, ar_n;
    logic [AW-1:0] wa, ra;
    logic [31:0]   wd, m;
    logic [3:0]    ws;
    int            idx;
    if (!ap_rst_n) begin
      aw_got <= 0; w_got <= 0; ar_got <= 0; bvalid <= 0; rvalid <= 0;
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0; ap_start_seen <= 0;
      for (int i = 0; i < 8; i++) s_mem[i] <= (i == 0) ? 32'h4 : 32'h0;
    end else begin
      aw_n = aw_got; wa = s_awaddr;
      w_n = w_got; wd = s_wdata; ws = s_wstrb;
      ar_n = ar_got; ra = s_araddr;
      if (bus.AWVALID && bus.AWREADY) begin aw_n = 1; wa = bus.AWADDR; aw_wait <= 0; end
      else if (bus.AWVALID) aw_wait <= aw_wait + 1;
      if (bus.WVALID && bus.WREADY) begin w_n = 1; wd = bus.WDATA; ws = bus.WSTRB; w_wait <= 0; end
      else if (bus.WVALID) w_wait <= w_wait + 1;
      if (bus.ARVALID && bus.ARREADY) begin ar_n = 1; ra = bus.ARADDR; ar_wait <= 0; end
      else if (bus.ARVALID) ar_wait <= ar_wait + 1;
      aw_got <= aw_n; s_awaddr <= wa; w_got <= w_n; s_wdata <= wd; s_wstrb <= ws;
      ar_got <= ar_n; s_araddr <= ra;
      if (bus.BVALID && bus.BREADY) bvalid <= 0;
      if (bus.RVALID && bus.RREADY) rvalid <= 0;
      if (aw_n && w_n && !bvalid) begin
        if (b_wait >= b_dly) begin
          idx = int'(wa[4:2]);
          m = {{8{ws[3]}}, {8{ws[2]}}, {8{ws[1]}}, {8{ws[0]}}};
          if (rule_resp(idx) == 2'b00) s_mem[idx] <= (s_mem[idx] & ~m) | (wd & m);
          if (idx == 0 && wd[0] && ws[0]) ap_start_seen <= 1;
          bvalid <= 1; bresp <= rule_resp(idx);
          aw_got <= 0; w_got <= 0; b_wait <= 0;
          wr_count <= wr_count + 1;
        end else b_wait <= b_wait + 1;
      end
      if (ar_n && !rvalid) begin
        if (r_wait >= r_dly) begin
          idx = int'(ra[4:2]);
          rvalid <= 1; rresp <= rule_resp(idx);
          rdata <= (rule_resp(idx) == 2'b00) ? s_mem[idx] : 32'h0;
          ar_got <= 0; r_wait <= 0;
        end else r_wait <= r_wait + 1;
      end
    end
  end

  // ---------------- resp_ready driver: 0 random, 1 always, 2 manual ----------------
  int rr_mode = 1;
  always @(posedge ap_clk) begin
    #1;
    if (rr_mode == 0) resp_ready = ($urandom_range(0, 2) != 0);
    else if (rr_mode == 1) resp_ready = 1'b1;
  end

  // ---------------- monitor: scoreboard pop + hold-until-handshake checks ----------------
  logic          p_rst = 0, p_aw = 0, p_w = 0, p_ar = 0, p_rsp = 0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [35:0]   p_wpay;
  logic [33:0]   p_rpay;

  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n && p_rst) begin
      if (p_aw)  check("aw_hold", {bus.AWVALID, bus.AWADDR}, {1'b1, p_awaddr});
      if (p_w)   check("w_hold", {bus.WVALID, bus.WDATA, bus.WSTRB}, {1'b1, p_wpay});
      if (p_ar)  check("ar_hold", {bus.ARVALID, bus.ARADDR}, {1'b1, p_araddr});
      if (p_rsp) check("resp_hold", {resp_valid, resp_rdata, resp_resp}, {1'b1, p_rpay});
    end
    if (ap_rst_n && resp_valid) check("cmd_ready_busy", cmd_ready, 0);
    if (ap_rst_n && resp_valid && resp_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL resp_unexpected: got rdata %0h resp %0h expected no response", resp_rdata, resp_resp);
      end else begin
        e = q.pop_front();
        check("resp", {resp_rdata, resp_resp}, {e.rdata, e.resp});
        if (e.w) n_wr_rsp++;
      end
    end
    p_rst    = ap_rst_n;
    p_aw     = bus.AWVALID && !bus.AWREADY; p_awaddr = bus.AWADDR;
    p_w      = bus.WVALID && !bus.WREADY;   p_wpay   = {bus.WDATA, bus.WSTRB};
    p_ar     = bus.ARVALID && !bus.ARREADY; p_araddr = bus.ARADDR;
    p_rsp    = resp_valid && !resp_ready;   p_rpay   = {resp_rdata, resp_resp};
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
  endtask

  // Returns the number of extra cycles spent waiting for cmd_ready.
  task automatic finish_accept(output int waited);
    waited = 0;
    forever begin
      @(negedge ap_clk);
      if (cmd_ready) break;
      waited++;
      if (waited > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL accept_timeout: got no cmd_ready expected accept within 300 cycles");
        break;
      end
    end
    if (cmd_ready) model_push(cmd_write, cmd_addr, cmd_wdata, cmd_wstrb);
    @(posedge ap_clk); #1;
    cmd_valid = 0;
    cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  task automatic do_cmd(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(posedge ap_clk); #1;
    issue(w, a, d, s);
    finish_accept(n);
  endtask

  task automatic set_dly(input int a, input int w, input int ar, input int b, input int r);
    aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin @(negedge ap_clk); n++; end
    if (q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", q.size());
    end
    @(posedge ap_clk); #1;
  endtask

  logic [2:0] skew_exp [1:5];
  int         wc0, n_acc;

  initial begin
    ref_reset();
    skew_exp[1] = 3'b110; skew_exp[2] = 3'b010; skew_exp[3] = 3'b010;
    skew_exp[4] = 3'b010; skew_exp[5] = 3'b001;

    // reset state
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_ctl", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY,
                      resp_valid, resp_resp, resp_rdata}, 0);
    check("rst_pay", {bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB}, 0);
    @(posedge ap_clk); #1 ap_rst_n = 1;
    @(negedge ap_clk);
    check("idle_cmd_ready", cmd_ready, 1);

    // read status register after reset, zero-wait slave
    set_dly(0, 0, 0, 0, 0);
    do_cmd(0, 5'h00, 32'h0, 4'h0);
    @(negedge ap_clk);
    check("rd_ar_t1", {bus.ARVALID, bus.ARADDR}, {1'b1, 5'h00});
    wait_drain();

    // ap_start write with zero-wait latency profile
    do_cmd(1, 5'h00, 32'h1, 4'hF);
    @(negedge ap_clk);
    check("wr_t1_valid", {bus.AWVALID, bus.WVALID}, 2'b11);
    check("wr_t1_pay", {bus.AWADDR, bus.WDATA, bus.WSTRB}, {5'h00, 32'h1, 4'hF});
    @(negedge ap_clk);
    check("wr_t2", {resp_valid, bus.BREADY}, 2'b01);
    @(negedge ap_clk);
    check("wr_t3_resp_valid", resp_valid, 1);
    wait_drain();
    check("ap_start_seen", ap_start_seen, 1);

    // skewed AW/W readiness
    set_dly(0, 3, 0, 0, 0);
    wc0 = wr_count;
    do_cmd(1, 5'h08, 32'hA5A5_0001, 4'hF);
    for (int k = 1; k <= 5; k++) begin
      @(negedge ap_clk);
      check($sformatf("skew_t%0d", k), {bus.AWVALID, bus.WVALID, bus.BREADY}, skew_exp[k]);
    end
    wait_drain();
    check("skew_one_write", wr_count, wc0 + 1);
    set_dly(0, 0, 0, 0, 0);

    // resp_ready stalled five cycles, then back-to-back command
    rr_mode = 2; resp_ready = 0;
    do_cmd(0, 5'h08, 32'h0, 4'h0);
    n_acc = 0;
    while (!resp_valid && n_acc < 50) begin @(negedge ap_clk); n_acc++; end
    check("stall_resp_seen", resp_valid, 1);
    repeat (5) begin
      @(negedge ap_clk);
      check("stall_state", {resp_valid, cmd_ready}, 2'b10);
    end
    @(posedge ap_clk); #1;
    resp_ready = 1;
    issue(1, 5'h04, 32'h1234_5678, 4'b0101);
    @(negedge ap_clk);
    check("release_cmd_ready", cmd_ready, 0);
    finish_accept(n_acc);
    check("accept_after_release", n_acc, 0);
    rr_mode = 1;
    wait_drain();

    // error responses pass through; traffic continues afterwards
    do_cmd(1, 5'h1C, 32'hFFFF_FFFF, 4'hF);
    do_cmd(0, 5'h1C, 32'h0, 4'h0);
    do_cmd(0, 5'h18, 32'h0, 4'h0);
    do_cmd(0, 5'h04, 32'h0, 4'h0);
    wait_drain();

    // randomised traffic
    rr_mode = 0;
    for (int i = 0; i < 60; i++) begin
      set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3));
      do_cmd(1'($urandom), {3'($urandom_range(0, 7)), 2'b00}, $urandom, 4'($urandom));
    end
    wait_drain();
    rr_mode = 1;

    // reset in the middle of a write
    set_dly(0, 10, 0, 0, 0);
    do_cmd(1, 5'h08, 32'hDEAD_0000, 4'hF);
    @(negedge ap_clk);
    check("mid_wr_wvalid", bus.WVALID, 1);
    @(posedge ap_clk); #1 ap_rst_n = 0;
    q.delete();
    ref_reset();
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst_mid_wr", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY,
                         resp_valid, cmd_ready}, 0);
    @(posedge ap_clk); #1 ap_rst_n = 1;
    set_dly(0, 0, 0, 0, 0);
    do_cmd(0, 5'h00, 32'h0, 4'h0);
    do_cmd(0, 5'h08, 32'h0, 4'h0);
    wait_drain();
    check("writes_reaching_slave", wr_count, n_wr_rsp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
